sys_rst_seq: RTL and testbench



---
 rtl/sys_rst_seq_if.sv | 34 +++
 rtl/sys_rst_seq.sv | 262 ++++++++++++++++++++++++++
 tb/tb_sys_rst_seq.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sys_rst_seq_if.sv
// sys_rst_seq_if: signal bundle between the reset sequencer and its SoC-side user.
//   master : drives PLL lock/straps and software reset requests, observes the rest
//   slave  : the sequencer (sys_rst_seq)
// Signals:
//   pll_lock     PLL lock, asynchronous to sys_clk
//   pll_cfg      PLL strap pins
//   sw_rst_req   per-domain software reset request (one-cycle pulses)
//   rst_n_out    per-domain active-low resets, bit 0 released first
//   pll_cfg_q    latched strap value
//   seq_done     high while all domains run
//   lock_timeout sticky flag, lock wait was bypassed
//   state_o      sequencer state (RESET=0 LATCH=1 WAIT_LOCK=2 RELEASE=3 RUN=4)
interface sys_rst_seq_if #(
  parameter int N_RST = 4
) ();
  logic             pll_lock;
  logic [5:0]       pll_cfg;
  logic [N_RST-1:0] sw_rst_req;
  logic [N_RST-1:0] rst_n_out;
  logic [5:0]       pll_cfg_q;
  logic             seq_done;
  logic             lock_timeout;
  logic [2:0]       state_o;

  modport master (
    output pll_lock, pll_cfg, sw_rst_req,
    input  rst_n_out, pll_cfg_q, seq_done, lock_timeout, state_o
  );

  modport slave (
    input  pll_lock, pll_cfg, sw_rst_req,
    output rst_n_out, pll_cfg_q, seq_done, lock_timeout, state_o
  );
endinterface

// File: rtl/sys_rst_seq.sv
// sys_rst_seq: power-on / run-time reset sequencer.
// Synchronises the board reset, latches the PLL straps, waits for a stable
// PLL lock and releases N_RST reset domains one per STAGE_CYCLES, lowest
// index first. In RUN each domain accepts a software reset pulse that holds
// it for STAGE_CYCLES cycles; losing lock re-sequences every domain.
// Optional feature: define SYS_RST_SEQ_LOCK_TIMEOUT_EN to bypass the lock
// wait after LOCK_TIMEOUT cycles (sets sticky lock_timeout, lock then ignored).
// Ports:
//   sys_clk  system clock
//   rst_n    board reset, asynchronous active-low
//   bus      sys_rst_seq_if.slave (lock, straps, sw requests, domain resets, status)

// Per-domain software reset hold counter and output register.
module sys_rst_seq_lane #(
  parameter int STAGE_CYCLES = 32
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic clr,        // abandon any hold (not running in RUN)
  input  logic req,        // start/restart a hold
  input  logic rel,        // domain released by the sequence, next value
  output logic dom_rst_n
);
  localparam int CW = $clog2(STAGE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(STAGE_CYCLES);

  logic [CW-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr)             cnt_nxt = '0;
    else if (req)        cnt_nxt = LOAD;
    else if (cnt != '0)  cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      dom_rst_n <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      dom_rst_n <= rel & (cnt_nxt == '0);
    end
  end
endmodule

module sys_rst_seq #(
  parameter int N_RST        = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_STABLE  = 16,
  parameter int STAGE_CYCLES = 32,
  parameter int LOCK_TIMEOUT = 4096
) (
  input logic          sys_clk,
  input logic          rst_n,
  sys_rst_seq_if.slave bus
);
  localparam logic [2:0] S_RESET   = 3'd0;
  localparam logic [2:0] S_LATCH   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_RUN     = 3'd4;

  localparam int LW = $clog2(LOCK_STABLE + 1);
  localparam int SW = $clog2(STAGE_CYCLES + 1);
  localparam int IW = (N_RST > 1) ? $clog2(N_RST) : 1;
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_STABLE - 1);
  localparam logic [SW-1:0] STG_LAST  = SW'(STAGE_CYCLES);
  localparam logic [SW-1:0] STG_ONE   = SW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_RST - 1);

  if (N_RST < 1 || N_RST > 16) begin : g_bad_n
    $error("sys_rst_seq: N_RST must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("sys_rst_seq: SYNC_STAGES must be >= 2");
  end
  if (LOCK_STABLE < 1 || STAGE_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_bad_cyc
    $error("sys_rst_seq: LOCK_STABLE, STAGE_CYCLES, LOCK_TIMEOUT must be >= 1");
  end

  // Reset release synchroniser: asserts with rst_n, deasserts on sys_clk.
  logic [SYNC_STAGES-1:0] rsync;
  logic                   rst_sync;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) rsync <= '0;
    else        rsync <= {rsync[SYNC_STAGES-2:0], 1'b1};
  end
  assign rst_sync = rsync[SYNC_STAGES-1];

  // PLL lock double-flop.
  logic [1:0] lsync;
  logic       lk;
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) lsync <= '0;
    else        lsync <= {lsync[0], bus.pll_lock};
  end
  assign lk = lsync[1];

  logic [2:0]       state, state_nxt;
  logic [LW-1:0]    lock_cnt, lock_cnt_nxt;
  logic [SW-1:0]    stg, stg_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [N_RST-1:0] rel, rel_nxt;
  logic [5:0]       cfg_q, cfg_nxt;
  logic             done, done_nxt;
  logic             to_q;
  logic             lost;

`ifdef SYS_RST_SEQ_LOCK_TIMEOUT_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT - 1);
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          to_nxt;
`else
  assign to_q = 1'b0;
`endif

  // Once the lock wait was bypassed the lock input is no longer trusted.
  assign lost = !lk && !to_q;

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    stg_nxt      = stg;
    idx_nxt      = idx;
    rel_nxt      = rel;
    cfg_nxt      = cfg_q;
    done_nxt     = done;
`ifdef SYS_RST_SEQ_LOCK_TIMEOUT_EN
    to_cnt_nxt   = to_cnt;
    to_nxt       = to_q;
`endif
    case (state)
      S_RESET: if (rst_sync) state_nxt = S_LATCH;
      S_LATCH: begin
        cfg_nxt = bus.pll_cfg;
        // The strap-latch cycle also serves as the first lock sample, so the
        // power-on release lands SYNC_STAGES+1+LOCK_STABLE edges after rst_n.
        lock_cnt_nxt = lk ? LW'(1) : '0;
`ifdef SYS_RST_SEQ_LOCK_TIMEOUT_EN
        to_cnt_nxt = '0;
`endif
        if (lk && LOCK_STABLE == 1) begin
          state_nxt = S_RELEASE;
          stg_nxt   = STG_ONE;
          idx_nxt   = '0;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lk && lock_cnt == LOCK_LAST) begin
          state_nxt    = S_RELEASE;
          stg_nxt      = STG_ONE;
          idx_nxt      = '0;
          lock_cnt_nxt = '0;
        end else begin
          lock_cnt_nxt = lk ? lock_cnt + 1'b1 : '0;
`ifdef SYS_RST_SEQ_LOCK_TIMEOUT_EN
          if (to_cnt == TO_LAST) begin
            to_nxt    = 1'b1;
            state_nxt = S_RELEASE;
            stg_nxt   = STG_ONE;
            idx_nxt   = '0;
          end else begin
            to_cnt_nxt = to_cnt + 1'b1;
          end
`endif
        end
      end
      S_RELEASE: begin
        if (lost) begin
          state_nxt    = S_WAIT;
          rel_nxt      = '0;
          lock_cnt_nxt = '0;
`ifdef SYS_RST_SEQ_LOCK_TIMEOUT_EN
          to_cnt_nxt   = '0;
`endif
        end else if (stg == STG_LAST) begin
          stg_nxt      = STG_ONE;
          rel_nxt[idx] = 1'b1;
          if (idx == IDX_LAST) begin
            state_nxt = S_RUN;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          stg_nxt = stg + 1'b1;
        end
      end
      S_RUN: begin
        if (lost) begin
          state_nxt    = S_WAIT;
          rel_nxt      = '0;
          done_nxt     = 1'b0;
          lock_cnt_nxt = '0;
`ifdef SYS_RST_SEQ_LOCK_TIMEOUT_EN
          to_cnt_nxt   = '0;
`endif
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RESET;
      lock_cnt <= '0;
      stg      <= '0;
      idx      <= '0;
      rel      <= '0;
      cfg_q    <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      lock_cnt <= lock_cnt_nxt;
      stg      <= stg_nxt;
      idx      <= idx_nxt;
      rel      <= rel_nxt;
      cfg_q    <= cfg_nxt;
      done     <= done_nxt;
    end
  end

`ifdef SYS_RST_SEQ_LOCK_TIMEOUT_EN
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      to_q   <= 1'b0;
    end else begin
      to_cnt <= to_cnt_nxt;
      to_q   <= to_nxt;
    end
  end
`endif

  // Software requests only count while staying in RUN; leaving RUN (or any
  // other state) clears every hold counter.
  logic             run_stay;
  logic [N_RST-1:0] rst_out;
  assign run_stay = (state == S_RUN) && (state_nxt == S_RUN);

  for (genvar i = 0; i < N_RST; i++) begin : g_lane
    sys_rst_seq_lane #(.STAGE_CYCLES(STAGE_CYCLES)) u_lane (
      .sys_clk   (sys_clk),
      .rst_n     (rst_n),
      .clr       (!run_stay),
      .req       (bus.sw_rst_req[i] & run_stay),
      .rel       (rel_nxt[i]),
      .dom_rst_n (rst_out[i])
    );
  end

  assign bus.rst_n_out    = rst_out;
  assign bus.pll_cfg_q    = cfg_q;
  assign bus.seq_done     = done;
  assign bus.lock_timeout = to_q;
  assign bus.state_o      = state;
endmodule

// File: tb/tb_sys_rst_seq.sv
// tb_sys_rst_seq: self-checking bench for sys_rst_seq (N_RST=3, SYNC_STAGES=2,
// LOCK_STABLE=4, STAGE_CYCLES=8, LOCK_TIMEOUT=64). Power-on release timing is
// checked from a vector table; lock loss, glitching lock, software reset and
// mid-sequence reset are hand sequences; random software requests are checked
// against an event-time model of the hold window.
module tb_sys_rst_seq;
  localparam int N  = 3;
  localparam int SS = 2;
  localparam int LS = 4;
  localparam int SC = 8;
  localparam int LT = 64;

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  sys_rst_seq_if #(.N_RST(N)) bus ();

  sys_rst_seq #(
    .N_RST(N), .SYNC_STAGES(SS), .LOCK_STABLE(LS),
    .STAGE_CYCLES(SC), .LOCK_TIMEOUT(LT)
  ) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  typedef struct {
    int           edge_no;  // edges after rst_n release
    logic [N-1:0] sw;       // sw_rst_req driven up to this edge (must be ignored)
    logic [N-1:0] out;
    logic         done;
    logic [2:0]   st;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    edge_n++;
  endtask

  // Reset, release rst_n and walk the table up to edge 'upto'.
  task automatic power_on(input logic [5:0] cfg, input int upto);
    rst_n = 1'b0;
    bus.pll_cfg    = cfg;
    bus.pll_lock   = 1'b1;
    bus.sw_rst_req = '0;
    repeat (3) step();
    chk("rst_out",  bus.rst_n_out, 0);
    chk("rst_done", bus.seq_done, 0);
    chk("rst_cfgq", bus.pll_cfg_q, 0);
    chk("rst_to",   bus.lock_timeout, 0);
    chk("rst_st",   bus.state_o, 0);
    rst_n  = 1'b1;
    edge_n = 0;
    for (int r = 0; r < 12; r++) begin
      if (tbl[r].edge_no <= upto) begin
        while (edge_n < tbl[r].edge_no) begin
          bus.sw_rst_req = tbl[r].sw;
          step();
        end
        chk($sformatf("po_e%0d_out", edge_n),  bus.rst_n_out, tbl[r].out);
        chk($sformatf("po_e%0d_done", edge_n), bus.seq_done, tbl[r].done);
        chk($sformatf("po_e%0d_st", edge_n),   bus.state_o, tbl[r].st);
        chk($sformatf("po_e%0d_cfg", edge_n),  bus.pll_cfg_q, (edge_n >= 4) ? cfg : 6'd0);
      end
    end
    bus.sw_rst_req = '0;
    while (edge_n < upto) step();
  endtask

  initial begin
    int           last [N];
    int           t;
    int           n;
    int           lowc;
    int           bad;
    logic [N-1:0] req;
    logic [N-1:0] exp_out;
    logic [5:0]   c2;

    // Edge k of bit i = SS + 1 + LS + (i+1)*SC -> 15, 23, 31.
    tbl[0]  = '{0,  3'b111, 3'b000, 1'b0, 3'd0};
    tbl[1]  = '{2,  3'b111, 3'b000, 1'b0, 3'd0};
    tbl[2]  = '{3,  3'b111, 3'b000, 1'b0, 3'd1};
    tbl[3]  = '{4,  3'b111, 3'b000, 1'b0, 3'd2};
    tbl[4]  = '{6,  3'b111, 3'b000, 1'b0, 3'd2};
    tbl[5]  = '{7,  3'b111, 3'b000, 1'b0, 3'd3};
    tbl[6]  = '{14, 3'b111, 3'b000, 1'b0, 3'd3};
    tbl[7]  = '{15, 3'b111, 3'b001, 1'b0, 3'd3};
    tbl[8]  = '{22, 3'b111, 3'b001, 1'b0, 3'd3};
    tbl[9]  = '{23, 3'b111, 3'b011, 1'b0, 3'd3};
    tbl[10] = '{30, 3'b111, 3'b011, 1'b0, 3'd3};
    tbl[11] = '{31, 3'b111, 3'b111, 1'b1, 3'd4};

    bus.pll_lock   = 1'b0;
    bus.pll_cfg    = '0;
    bus.sw_rst_req = '0;

    // Power-on with straps 000001.
    power_on(6'b000001, 31);
    bus.pll_cfg = 6'b111110;   // must not be re-latched
    step();
    chk("run_cfg_hold", bus.pll_cfg_q, 6'b000001);

    // Software reset on domain 1, repeated 4 cycles later: 12 cycles low.
    lowc = 0;
    bad  = 0;
    for (int k = 0; k <= 20; k++) begin
      bus.sw_rst_req = (k == 0 || k == 4) ? 3'b010 : 3'b000;
      step();
      if (!bus.rst_n_out[1]) lowc++;
      if (!bus.rst_n_out[0] || !bus.rst_n_out[2]) bad++;
    end
    chk("sw_low_cycles", lowc, 12);
    chk("sw_others_hi", bad, 0);
    chk("sw_final_out", bus.rst_n_out, 3'b111);

    // Random software requests against the hold-window model.
    for (int i = 0; i < N; i++) last[i] = -1000;
    t = 0;
    repeat (300) begin
      for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 9) == 0);
      bus.sw_rst_req = req;
      step();
      t++;
      for (int i = 0; i < N; i++) begin
        if (req[i]) last[i] = t;
        exp_out[i] = !((t - last[i]) < SC);
      end
      chk("rand_sw_out", bus.rst_n_out, exp_out);
    end
    bus.sw_rst_req = '0;
    repeat (SC) step();
    chk("rand_sw_settle", bus.rst_n_out, 3'b111);
    chk("rand_sw_done", bus.seq_done, 1);

    // Lock loss in RUN: outputs fall on the 3rd edge after the pin.
    bus.pll_lock = 1'b0;
    step();
    step();
    chk("ll_e2_out", bus.rst_n_out, 3'b111);
    step();
    chk("ll_e3_out",  bus.rst_n_out, 3'b000);
    chk("ll_e3_done", bus.seq_done, 0);
    chk("ll_e3_st",   bus.state_o, 2);
`ifndef SYS_RST_SEQ_LOCK_TIMEOUT_EN
    chk("ll_to_flag", bus.lock_timeout, 0);
`endif

    // Glitching lock: low one cycle in three, never 4 clean cycles.
    for (int j = 0; j < 12; j++) begin
      bus.pll_lock = (j % 3 != 2);
      bus.sw_rst_req = 3'b111;   // ignored outside RUN
      step();
      chk("glitch_st", bus.state_o, 2);
    end
    bus.sw_rst_req = '0;
    bus.pll_lock   = 1'b1;
    n = 0;
    while (bus.state_o != 3'd3 && n < 50) begin
      step();
      n++;
    end
    chk("relock_edges", n, 2 + LS);
    repeat (SC - 1) step();
    chk("rr_b0_pre", bus.rst_n_out, 3'b000);
    step();
    chk("rr_b0", bus.rst_n_out, 3'b001);
    repeat (SC) step();
    chk("rr_b1", bus.rst_n_out, 3'b011);
    repeat (SC) step();
    chk("rr_b2",   bus.rst_n_out, 3'b111);
    chk("rr_done", bus.seq_done, 1);
    chk("rr_cfg",  bus.pll_cfg_q, 6'b000001);

    // Reset mid-sequence: asynchronous clear without a clock edge.
    c2 = 6'($urandom_range(1, 63));
    power_on(c2, 18);
    chk("mid_pre_out", bus.rst_n_out, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_out",  bus.rst_n_out, 0);
    chk("mid_async_done", bus.seq_done, 0);
    chk("mid_async_cfg",  bus.pll_cfg_q, 0);
    chk("mid_async_st",   bus.state_o, 0);
    c2 = 6'($urandom_range(0, 63));
    power_on(c2, 31);

`ifdef SYS_RST_SEQ_LOCK_TIMEOUT_EN
    // Lock never arrives: bypass after LT cycles in WAIT_LOCK (entered at edge 4).
    rst_n = 1'b0;
    bus.pll_lock = 1'b0;
    repeat (3) step();
    rst_n  = 1'b1;
    edge_n = 0;
    while (!bus.lock_timeout && edge_n < 200) step();
    chk("to_edge", edge_n, 4 + LT);
    chk("to_st", bus.state_o, 3);
    for (int k = 0; k < N * SC; k++) begin
      bus.pll_lock = 1'($urandom_range(0, 1));
      step();
    end
    chk("to_out",  bus.rst_n_out, 3'b111);
    chk("to_done", bus.seq_done, 1);
    repeat (10) begin
      bus.pll_lock = 1'($urandom_range(0, 1));
      step();
    end
    chk("to_run_out", bus.rst_n_out, 3'b111);
    chk("to_sticky", bus.lock_timeout, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
